// File: rtl/rot_pkg.sv
// Shared constants and Gray-code helpers for the rotary quadrature decoder.
package rot_pkg;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

    // A full detent is four quarter-steps; one spare bit lets the accumulator hold +4.
    localparam int ACC_DETENT = 4;
    localparam int ACC_W      = 4;

    typedef enum logic [1:0] {
        GRAY_NONE,
        GRAY_CW,
        GRAY_CCW,
        GRAY_ILLEGAL
    } gray_dir_e;

    function automatic logic [1:0] gray_index(input logic [1:0] ab);
        case (ab)
            AB_00:   return 2'd0;
            AB_01:   return 2'd1;
            AB_11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic gray_dir_e gray_dir(input logic [1:0] prev, input logic [1:0] next);
        logic [1:0] diff;
        diff = gray_index(next) - gray_index(prev);
        case (diff)
            2'd0:    return GRAY_NONE;
            2'd1:    return GRAY_CW;
            2'd3:    return GRAY_CCW;
            default: return GRAY_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only follows
// the synchronized input after it has differed for FILTER_LEN consecutive cycles.
module sync_filter #(
    parameter int   FILTER_LEN = 16,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_BITS = $clog2(FILTER_LEN);

    logic                meta_q;
    logic                sync_q;
    logic                filt_q;
    logic                filt_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            filt_q <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_BITS'(FILTER_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/rot_quad_decoder.sv
// Rotary encoder decoder: filtered quadrature to detent steps, direction and position.
// Define ROT_ACCEL_EN to enable +/-4 acceleration for fast same-direction detents.
module rot_quad_decoder
    import rot_pkg::*;
#(
    parameter int         FILTER_LEN = 16,
    parameter int         CNT_W      = 8,
    parameter bit         WRAP       = 1'b1,
    parameter logic [1:0] REST_AB    = 2'b00
`ifdef ROT_ACCEL_EN
    ,
    parameter int         ACCEL_WIN  = 2_500_000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rot_a,
    input  logic                    rot_b,
    input  logic                    rot_center,
    input  logic                    clr,
    output logic signed [CNT_W-1:0] position,
    output logic                    step_cw,
    output logic                    step_ccw,
    output logic                    dir,
    output logic                    center_level,
    output logic                    center_pulse,
    output logic                    err
);

    localparam logic signed [ACC_W-1:0] ACC_CW_DETENT  = ACC_W'(ACC_DETENT);
    localparam logic signed [ACC_W-1:0] ACC_CCW_DETENT = ACC_W'(-ACC_DETENT);
    localparam logic signed [CNT_W:0]   POS_MAX = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0]   POS_MIN = {2'b11, {(CNT_W-1){1'b0}}};

    logic                    a_f, b_f, center_f;
    logic [1:0]              ab_f;
    logic [1:0]              ab_prev_q;
    gray_dir_e               move;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    step_cw_q, step_cw_d;
    logic                    step_ccw_q, step_ccw_d;
    logic                    err_q, err_d;
    logic                    dir_q, dir_d;
    logic                    center_prev_q, center_pulse_q;
    logic signed [CNT_W-1:0] position_q, position_d;
    logic        [CNT_W:0]   mag;
    logic signed [CNT_W:0]   delta, pos_sum;

    sync_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(REST_AB[1])) u_filt_a (
        .clk(clk), .rst(rst), .din(rot_a), .dout(a_f)
    );
    sync_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(REST_AB[0])) u_filt_b (
        .clk(clk), .rst(rst), .din(rot_b), .dout(b_f)
    );
    sync_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_filt_center (
        .clk(clk), .rst(rst), .din(rot_center), .dout(center_f)
    );

    assign ab_f = {a_f, b_f};

    // Quarter-steps accumulate between detents; a step is only credited when the
    // filtered inputs return to the rest code after exactly four same-direction moves.
    always_comb begin
        move       = gray_dir(ab_prev_q, ab_f);
        acc_d      = acc_q;
        step_cw_d  = 1'b0;
        step_ccw_d = 1'b0;
        err_d      = 1'b0;
        dir_d      = dir_q;
        case (move)
            GRAY_CW:      acc_d = acc_q + ACC_W'(1);
            GRAY_CCW:     acc_d = acc_q - ACC_W'(1);
            GRAY_ILLEGAL: begin
                err_d = 1'b1;
                acc_d = '0;
            end
            default: ;
        endcase
        if ((move == GRAY_CW || move == GRAY_CCW) && ab_f == REST_AB) begin
            if (acc_d == ACC_CW_DETENT) begin
                step_cw_d = 1'b1;
                dir_d     = 1'b1;
            end else if (acc_d == ACC_CCW_DETENT) begin
                step_ccw_d = 1'b1;
                dir_d      = 1'b0;
            end
            acc_d = '0;
        end
    end

`ifdef ROT_ACCEL_EN
    localparam int ACCEL_STEP = 4;
    localparam int TIMER_W    = $clog2(ACCEL_WIN + 1);

    logic [TIMER_W-1:0] since_q;
    logic               armed_q;
    logic               last_cw_q;
    logic               accel_fast;

    assign accel_fast = armed_q && (since_q < TIMER_W'(ACCEL_WIN)) && (last_cw_q == step_cw_q);

    // Cycles since the last credited step saturate at the window so the timer never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            since_q   <= '0;
            armed_q   <= 1'b0;
            last_cw_q <= 1'b0;
        end else if (clr) begin
            since_q <= '0;
            armed_q <= 1'b0;
        end else if (step_cw_q || step_ccw_q) begin
            since_q   <= '0;
            armed_q   <= 1'b1;
            last_cw_q <= step_cw_q;
        end else if (since_q < TIMER_W'(ACCEL_WIN)) begin
            since_q <= since_q + 1'b1;
        end
    end
`endif

    // The sum is formed one bit wider so saturation can detect overflow either way.
    always_comb begin
        mag = (CNT_W+1)'(1);
`ifdef ROT_ACCEL_EN
        if (accel_fast) mag = (CNT_W+1)'(ACCEL_STEP);
`endif
        delta      = step_ccw_q ? -$signed(mag) : $signed(mag);
        pos_sum    = {position_q[CNT_W-1], position_q} + delta;
        position_d = position_q;
        if (clr) begin
            position_d = '0;
        end else if (step_cw_q || step_ccw_q) begin
            if (WRAP)                   position_d = pos_sum[CNT_W-1:0];
            else if (pos_sum > POS_MAX) position_d = POS_MAX[CNT_W-1:0];
            else if (pos_sum < POS_MIN) position_d = POS_MIN[CNT_W-1:0];
            else                        position_d = pos_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ab_prev_q      <= REST_AB;
            acc_q          <= '0;
            step_cw_q      <= 1'b0;
            step_ccw_q     <= 1'b0;
            err_q          <= 1'b0;
            dir_q          <= 1'b0;
            center_prev_q  <= 1'b0;
            center_pulse_q <= 1'b0;
            position_q     <= '0;
        end else begin
            ab_prev_q      <= ab_f;
            acc_q          <= acc_d;
            step_cw_q      <= step_cw_d;
            step_ccw_q     <= step_ccw_d;
            err_q          <= err_d;
            dir_q          <= dir_d;
            center_prev_q  <= center_f;
            center_pulse_q <= center_f & ~center_prev_q;
            position_q     <= position_d;
        end
    end

    assign position     = position_q;
    assign step_cw      = step_cw_q;
    assign step_ccw     = step_ccw_q;
    assign dir          = dir_q;
    assign err          = err_q;
    assign center_level = center_f;
    assign center_pulse = center_pulse_q;

endmodule
